// File: rtl/bcd_to_bin.sv
// Serial BCD-to-binary converter using reverse double-dabble.
// Each SHIFT cycle moves one bit from the BCD register into the binary
// accumulator, then applies a per-digit subtract-3 correction.
// Inputs with any digit above 9 are flagged and return all-ones.
module bcd_to_bin #(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned BIN_W  = 14
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int unsigned CNT_W = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                state;
   logic [4*DIGITS-1:0]   bcd_reg;
   logic [BIN_W-1:0]      acc;
   logic [CNT_W-1:0]      count;
   logic                  error;

   logic                  in_bad;
   logic [4*DIGITS-1:0]   bcd_shift;
   logic [4*DIGITS-1:0]   bcd_next;
   logic [BIN_W-1:0]      acc_next;

   // Flag any input digit outside 0..9.
   always_comb begin
      in_bad = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (bcd_in[4*i +: 4] > 4'd9) in_bad = 1'b1;
      end
   end

   // One shift step: move {bcd_reg,acc} right, then correct each digit >= 8.
   always_comb begin
      {bcd_shift, acc_next} = {bcd_reg, acc} >> 1;
      bcd_next = bcd_shift;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (bcd_shift[4*i +: 4] >= 4'd8)
            bcd_next[4*i +: 4] = bcd_shift[4*i +: 4] - 4'd3;
      end
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state   <= IDLE;
         bcd_reg <= '0;
         acc     <= '0;
         count   <= '0;
         error   <= 1'b0;
         bin_out <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  bcd_reg <= bcd_in;
                  acc     <= '0;
                  count   <= '0;
                  busy    <= 1'b1;
                  error   <= in_bad;
                  state   <= in_bad ? DONE : SHIFT;
               end
            end
            SHIFT: begin
               bcd_reg <= bcd_next;
               acc     <= acc_next;
               count   <= count + 1'b1;
               if (count == LAST) state <= DONE;
            end
            DONE: begin
               bin_out <= error ? '1 : acc;
               err     <= error;
               done    <= 1'b1;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
